// File: rtl/bubble_sort_pkg.sv
// Shared types and sizes for the in-place bubble sort sequencer.
package bubble_sort_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned CNT_W  = 10;
    localparam int unsigned LEN_W  = 6;

    typedef enum logic [2:0] {
        StIdle,
        StReadA,
        StReadB,
        StCompare,
        StWriteA,
        StWriteB,
        StNext,
        StDone
    } state_e;

endpackage

// File: rtl/bubble_sort_controller_if.sv
// Control handshake plus memory port between the sort sequencer and its memory.
interface bubble_sort_controller_if;
    import bubble_sort_pkg::*;

    logic              Start;
    logic [LEN_W-1:0]  Length;
    logic              Busy;
    logic              Done;
    logic [CNT_W-1:0]  SwapCount;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] WriteData;
    logic              MemWrite;
    logic              MemRead;
    logic [DATA_W-1:0] ReadData;

    modport master (
        input  Start, Length, ReadData,
        output Busy, Done, SwapCount, Address, WriteData, MemWrite, MemRead
    );

    modport slave (
        output Start, Length, ReadData,
        input  Busy, Done, SwapCount, Address, WriteData, MemWrite, MemRead
    );

endinterface

// File: rtl/bubble_sort_controller.sv
// Sorts mem[0..Length-1] ascending in place with early-exit bubble sort.
// Memory reads are combinational; writes commit on the rising edge.
module bubble_sort_controller
    import bubble_sort_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    bubble_sort_controller_if.master bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] limit_q, limit_d;
    logic              swapped_q, swapped_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [LEN_W-1:0]  len_clamp;
    logic [ADDR_W-1:0] idx_inc;

    assign len_clamp = (bus.Length > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : bus.Length;
    assign idx_inc   = idx_q + ADDR_W'(1);

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            idx_q     <= '0;
            limit_q   <= '0;
            swapped_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
        end else begin
            idx_q     <= idx_d;
            limit_q   <= limit_d;
            swapped_q <= swapped_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        limit_d   = limit_q;
        swapped_d = swapped_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.Start) begin
                    // limit is the index of the last pair's right element for this pass
                    limit_d   = (len_clamp <= LEN_W'(1)) ? '0 : ADDR_W'(len_clamp - LEN_W'(1));
                    idx_d     = '0;
                    swapped_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = (len_clamp <= LEN_W'(1)) ? StDone : StReadA;
                end
            end
            StReadA: begin
                a_d     = bus.ReadData;
                state_d = StReadB;
            end
            StReadB: begin
                b_d     = bus.ReadData;
                state_d = StCompare;
            end
            StCompare: state_d = (a_q > b_q) ? StWriteA : StNext;
            StWriteA:  state_d = StWriteB;
            StWriteB: begin
                swapped_d = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                state_d   = StNext;
            end
            StNext: begin
                if (idx_inc < limit_q) begin
                    idx_d   = idx_inc;
                    state_d = StReadA;
                end else if (!swapped_q || limit_q == ADDR_W'(1)) begin
                    state_d = StDone;
                end else begin
                    // The largest element has bubbled to the end; shrink the window.
                    limit_d   = limit_q - ADDR_W'(1);
                    idx_d     = '0;
                    swapped_d = 1'b0;
                    state_d   = StReadA;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.Busy      = (state_q != StIdle);
        bus.Done      = (state_q == StDone);
        bus.SwapCount = cnt_q;
        bus.Address   = '0;
        bus.WriteData = '0;
        bus.MemWrite  = 1'b0;
        bus.MemRead   = 1'b0;
        unique case (state_q)
            StReadA: begin
                bus.Address = idx_q;
                bus.MemRead = 1'b1;
            end
            StReadB: begin
                bus.Address = idx_inc;
                bus.MemRead = 1'b1;
            end
            StWriteA: begin
                bus.Address   = idx_q;
                bus.WriteData = b_q;
                bus.MemWrite  = 1'b1;
            end
            StWriteB: begin
                bus.Address   = idx_inc;
                bus.WriteData = a_q;
                bus.MemWrite  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
